// File: rtl/logic_rs.sv
// Reservation station for the 32-bit logic unit: holds issued ops until both
// operands are known, dispatches to the logic unit, and broadcasts on the CDB.
module logic_rs #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int BASE_TAG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [2:0]       iss_op,
  input  logic [TAG_W-1:0] iss_qj,
  input  logic [31:0]      iss_vj,
  input  logic [TAG_W-1:0] iss_qk,
  input  logic [31:0]      iss_vk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [31:0]      lu_a,
  output logic [31:0]      lu_b,
  output logic [2:0]       lu_sel,
  input  logic [31:0]      lu_out,
  output logic             cdb_req,
  output logic [TAG_W-1:0] cdb_req_tag,
  output logic [31:0]      cdb_req_data,
  input  logic             cdb_grant
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_FREE = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2, S_EXEC = 2'd3;

  logic [1:0]       st [DEPTH], st_n [DEPTH];
  logic [2:0]       op [DEPTH], op_n [DEPTH];
  logic [31:0]      vj [DEPTH], vj_n [DEPTH];
  logic [31:0]      vk [DEPTH], vk_n [DEPTH];
  logic [TAG_W-1:0] qj [DEPTH], qj_n [DEPTH];
  logic [TAG_W-1:0] qk [DEPTH], qk_n [DEPTH];

  logic             ex_valid, ex_valid_n;
  logic [TAG_W-1:0] ex_tag, ex_tag_n;
  logic [31:0]      ex_a, ex_a_n, ex_b, ex_b_n;
  logic [2:0]       ex_op, ex_op_n;
  logic             wb_valid, wb_valid_n;
  logic [TAG_W-1:0] wb_tag, wb_tag_n;
  logic [31:0]      wb_data, wb_data_n;

  logic             wb_ok, ex_ok, has_free, has_rdy;
  logic [IDX_W-1:0] alloc_idx, disp_idx;
  logic [TAG_W-1:0] fj, fk;
  logic [31:0]      fvj, fvk;

  function automatic logic [TAG_W-1:0] ent_tag(input int i);
    return TAG_W'(BASE_TAG + i);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i] <= S_FREE;
        op[i] <= '0;
        vj[i] <= '0;
        vk[i] <= '0;
        qj[i] <= '0;
        qk[i] <= '0;
      end
      ex_valid <= 1'b0;
      ex_tag   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_op    <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
    end else begin
      st       <= st_n;
      op       <= op_n;
      vj       <= vj_n;
      vk       <= vk_n;
      qj       <= qj_n;
      qk       <= qk_n;
      ex_valid <= ex_valid_n;
      ex_tag   <= ex_tag_n;
      ex_a     <= ex_a_n;
      ex_b     <= ex_b_n;
      ex_op    <= ex_op_n;
      wb_valid <= wb_valid_n;
      wb_tag   <= wb_tag_n;
      wb_data  <= wb_data_n;
    end
  end

  always_comb begin
    st_n = st;
    op_n = op;
    vj_n = vj;
    vk_n = vk;
    qj_n = qj;
    qk_n = qk;
    ex_valid_n = ex_valid;
    ex_tag_n   = ex_tag;
    ex_a_n     = ex_a;
    ex_b_n     = ex_b;
    ex_op_n    = ex_op;
    wb_valid_n = wb_valid;
    wb_tag_n   = wb_tag;
    wb_data_n  = wb_data;
    has_free  = 1'b0;
    has_rdy   = 1'b0;
    alloc_idx = '0;
    disp_idx  = '0;
    fj  = iss_qj;
    fk  = iss_qk;
    fvj = iss_vj;
    fvk = iss_vk;

    // Downward scan so the lowest index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st[i] == S_FREE) begin
        has_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (st[i] == S_READY) begin
        has_rdy  = 1'b1;
        disp_idx = IDX_W'(i);
      end
    end

    wb_ok = !wb_valid || cdb_grant;
    ex_ok = !ex_valid || wb_ok;

    for (int i = 0; i < DEPTH; i++) begin
      if (st[i] == S_WAIT) begin
        if (cdb_valid && qj[i] != '0 && qj[i] == cdb_tag) begin
          vj_n[i] = cdb_data;
          qj_n[i] = '0;
        end
        if (cdb_valid && qk[i] != '0 && qk[i] == cdb_tag) begin
          vk_n[i] = cdb_data;
          qk_n[i] = '0;
        end
        if (qj_n[i] == '0 && qk_n[i] == '0)
          st_n[i] = S_READY;
      end
      if (wb_valid && cdb_grant && st[i] == S_EXEC && wb_tag == ent_tag(i))
        st_n[i] = S_FREE;
    end

    if (ex_ok) begin
      ex_valid_n = has_rdy;
      if (has_rdy) begin
        ex_tag_n = ent_tag(int'(disp_idx));
        ex_a_n   = vj[disp_idx];
        ex_b_n   = vk[disp_idx];
        ex_op_n  = op[disp_idx];
        st_n[disp_idx] = S_EXEC;
      end else begin
        ex_tag_n = '0;
        ex_a_n   = '0;
        ex_b_n   = '0;
        ex_op_n  = '0;
      end
    end

    if (wb_ok) begin
      wb_valid_n = ex_valid;
      wb_tag_n   = ex_valid ? ex_tag : '0;
      wb_data_n  = ex_valid ? lu_out : '0;
    end

    if (iss_valid && has_free) begin
      if (cdb_valid && fj != '0 && fj == cdb_tag) begin
        fj  = '0;
        fvj = cdb_data;
      end
      if (cdb_valid && fk != '0 && fk == cdb_tag) begin
        fk  = '0;
        fvk = cdb_data;
      end
      op_n[alloc_idx] = iss_op;
      vj_n[alloc_idx] = fvj;
      vk_n[alloc_idx] = fvk;
      qj_n[alloc_idx] = fj;
      qk_n[alloc_idx] = fk;
      st_n[alloc_idx] = (fj == '0 && fk == '0) ? S_READY : S_WAIT;
    end
  end

  always_comb begin
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (st[i] == S_FREE) iss_ready = 1'b1;
    lu_a         = ex_valid ? ex_a  : '0;
    lu_b         = ex_valid ? ex_b  : '0;
    lu_sel       = ex_valid ? ex_op : '0;
    cdb_req      = wb_valid;
    cdb_req_tag  = wb_tag;
    cdb_req_data = wb_data;
  end
endmodule

// File: doc/logic_rs.md
Name: logic_rs

Overview:
- Reservation station that feeds the 32-bit logic unit in the Tomasulo core and returns its results.
- Accepts issued logic ops with operand values or producer tags, and snoops the common data bus (CDB) for missing operands.
- Dispatches ready ops to the combinational logic unit, registers each result, and broadcasts it on the CDB under its own tag with a request/grant handshake.

Parameters:
DEPTH, 4, number of station entries (2..8)
TAG_W, 4, tag width; tag 0 means "value present"
BASE_TAG, 8, tag of entry i is BASE_TAG+i; nonzero, fits TAG_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
iss_valid  in  1  issue request
iss_ready  out  1  at least one FREE entry (combinational)
iss_op  in  3  logic select: 000 AND, 001 OR, 010 NOR, 011 NAND, 100 XOR, 101 XNOR, 110 NOT a, 111 two's-complement a
iss_qj  in  TAG_W  producer tag of a (0 = iss_vj valid)
iss_vj  in  32  operand a value
iss_qk  in  TAG_W  producer tag of b (0 = iss_vk valid)
iss_vk  in  32  operand b value
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
cdb_data  in  32  CDB broadcast data
lu_a  out  32  operand a to logic unit
lu_b  out  32  operand b to logic unit
lu_sel  out  3  select to logic unit
lu_out  in  32  combinational logic unit result
cdb_req  out  1  result waiting for CDB
cdb_req_tag  out  TAG_W  tag of waiting result
cdb_req_data  out  32  waiting result
cdb_grant  in  1  CDB accepts request this cycle

Behaviour:
- Entry states: FREE, WAIT (operand tag pending), READY, EXEC (dispatched, awaiting broadcast).
- Issue:
  - Fires when iss_valid && iss_ready.
  - Allocates the lowest-index FREE entry. Entry goes to READY if both tags are 0 after forwarding, otherwise WAIT.
  - iss_valid while !iss_ready is ignored; no state change.
- Capture:
  - Every cycle, for each WAIT entry, each operand with q != 0 and q == cdb_tag while cdb_valid loads cdb_data and clears q.
  - Same-cycle forward: an issue with iss_qj or iss_qk matching a valid CDB tag captures cdb_data at issue.
  - The station's own broadcasts are snooped like any other.
- Dispatch:
  - Ex stage register holds ex_valid/tag/a/b/op and drives lu_a/lu_b/lu_sel; these are 0 when ex is invalid.
  - The lowest-index READY entry loads into ex when ex is empty or advancing. The entry becomes EXEC.
  - An entry that becomes READY at edge N can dispatch at edge N+1 at the earliest.
- Writeback:
  - The wb register captures {ex_tag, lu_out} when wb is empty or granted this cycle.
  - cdb_req = wb_valid. cdb_req_tag and cdb_req_data come straight from the wb register.
- Handshake:
  - On cdb_req && cdb_grant, wb clears at the next edge and the matching entry becomes FREE.
  - A freed entry is visible on iss_ready the following cycle.
  - cdb_grant without cdb_req is ignored.
- Backpressure:
  - While cdb_req && !cdb_grant, wb holds with tag/data stable.
  - ex holds if wb is full and not granted; no dispatch while ex holds.
- Latency, both operands present at issue edge E0 and no stall: dispatch at E1, wb loaded at E2, cdb_req high from E2. Grant in that cycle frees the entry at E3.
- Ordering: no reordering within a pipeline stage; selection among READY entries is by lowest index, not age.
- Reset: all entries FREE, ex and wb invalid, cdb_req 0, cdb_req_tag/data 0, lu_a/lu_b/lu_sel 0. iss_ready is 1 in the cycle after reset. Reset mid-operation discards all entries and in-flight results with no broadcast.

Test Plan:
1. Issue op 001, vj=0x000000F0, vk=0x0000000F, qj=qk=0 -> cdb_req from E2 with tag 8, data 0x000000FF; grant -> entry 0 FREE, cdb_req low at E3.
2. Issue op 111, vj=0x00000001 -> data 0xFFFFFFFF; op 010, vj=vk=0 -> 0xFFFFFFFF; op 101, vj=0x0F0F0F0F, vk=0x0F0F0F0F -> 0xFFFFFFFF.
3. Issue op 100, qj=3, vk=0xFFFFFFFF; two cycles later CDB tag 3 data 0xAAAAAAAA -> broadcast tag 8, data 0x55555555. Repeat with the CDB tag 3 in the issue cycle (forward) -> same result.
4. Fill all 4 entries waiting on qj=5 -> iss_ready 0 and a 5th issue is ignored. CDB tag 5 -> results broadcast with tags 8, 9, 10, 11 in that order, grant held high.
5. Result pending with cdb_grant low for 5 cycles -> cdb_req_tag and cdb_req_data stable, no dispatch while ex is full; grant -> queue drains.
6. Assert rst with 3 entries WAIT and wb full -> next cycle cdb_req 0, iss_ready 1, lu_* 0; a later CDB tag 5 produces no broadcast.
